// File: rtl/segasys1_io_pkg.sv
// Shared constants for the System 1 main-CPU I/O controller: port addresses,
// input-group codes, status bit positions and the read-select vector.
package segasys1_io_pkg;

  localparam logic [7:0] SND_A0 = 8'h14;
  localparam logic [7:0] SND_A1 = 8'h18;
  localparam logic [7:0] VID_A0 = 8'h15;
  localparam logic [7:0] VID_A1 = 8'h19;
  localparam logic [7:0] STS_A0 = 8'h16;
  localparam logic [7:0] STS_A1 = 8'h1A;

  localparam int STS_OVF   = 7;
  localparam int STS_EMPTY = 6;
  localparam int STS_FULL  = 5;

  // A[4:2] group codes for the input/DIP ports
  typedef enum logic [2:0] {
    GRP_INP0 = 3'b000,
    GRP_INP1 = 3'b001,
    GRP_INP2 = 3'b010,
    GRP_DSW  = 3'b011,
    GRP_DSW1 = 3'b100
  } in_grp_e;

  typedef struct packed {
    logic inp0;
    logic inp1;
    logic inp2;
    logic dsw0;
    logic dsw1;
    logic snd;
    logic vid;
    logic sts;
  } rd_sel_t;

  function automatic logic is_port(input logic [7:0] addr, input logic [7:0] p0,
                                   input logic [7:0] p1);
    return (addr == p0) || (addr == p1);
  endfunction

endpackage

// File: rtl/segasys1_io_ctrl_if.sv
// Z80 I/O-space bus as seen by the I/O controller: strobes and write data in,
// combinational read data out.
interface segasys1_io_ctrl_if;
  logic       CPUCE;
  logic [7:0] CPUAD;
  logic       CPUIORQ;
  logic       CPURD;
  logic       CPUWR;
  logic [7:0] CPUDO;
  logic       DV;
  logic [7:0] OD;

  modport master (output CPUCE, CPUAD, CPUIORQ, CPURD, CPUWR, CPUDO, input DV, OD);
  modport slave  (input CPUCE, CPUAD, CPUIORQ, CPURD, CPUWR, CPUDO, output DV, OD);
endinterface

// File: rtl/segasys1_snd_fifo.sv
// Sound-command mailbox FIFO: 8-bit entries, write-through head, sticky overflow
// flag, simultaneous push/pop allowed even when full.
module segasys1_snd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       CLK48M,
  input  logic       RESETn,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  input  logic       ovf_clr,
  output logic [7:0] head,
  output logic       empty,
  output logic       full,
  output logic [3:0] count4,
  output logic       ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: the data array has no reset; occupancy lives in count/pointers only.
  always_ff @(posedge CLK48M) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge CLK48M or negedge RESETn) begin
    if (!RESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // a dropped push outranks a same-cycle clear
      if (push & full & ~do_pop) ovf <= 1'b1;
      else if (ovf_clr)          ovf <= 1'b0;
    end
  end

  assign head = empty ? 8'h00 : mem[rd_ptr];

  generate
    if (CW >= 4) begin : g_cnt_trunc
      assign count4 = count[3:0];
    end else begin : g_cnt_ext
      assign count4 = {{(4-CW){1'b0}}, count};
    end
  endgenerate

endmodule

// File: rtl/segasys1_io_ctrl.sv
// System 1 main-CPU I/O controller: input/DIP read ports, video-mode latch,
// sound-command FIFO mailbox and status port on the Z80 I/O space.
module segasys1_io_ctrl
  import segasys1_io_pkg::*;
#(
  parameter int         SND_DEPTH = 4,
  parameter bit         INP_LATCH = 1'b0,
  parameter logic [7:0] VIDMD_RST = 8'h00
) (
  input  logic                CLK48M,
  input  logic                RESETn,
  segasys1_io_ctrl_if.slave   bus,
  input  logic [7:0]          INP0,
  input  logic [7:0]          INP1,
  input  logic [7:0]          INP2,
  input  logic [7:0]          DSW0,
  input  logic [7:0]          DSW1,
  input  logic                VBLK,
  output logic [7:0]          VIDMD,
  output logic                SNDRQ,
  output logic [7:0]          SNDNO,
  input  logic                SNDACK
);

  logic       wr_now, wr_q, wr_commit;
  logic       snd_push, vid_wr, ovf_clr;
  logic       vblk_q;
  logic [7:0] lat0, lat1, lat2;
  logic [7:0] inp0_v, inp1_v, inp2_v;
  logic       snd_empty, snd_full, snd_ovf;
  logic [3:0] snd_cnt;
  logic [7:0] status, rd_data;
  rd_sel_t    sel;

  assign wr_now = bus.CPUIORQ & bus.CPUWR;

  // wr_q resets high so a strobe held across reset release never commits
  always_ff @(posedge CLK48M or negedge RESETn) begin
    if (!RESETn) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      wr_q <= 1'b1;
    end else if (bus.CPUCE) begin
      wr_q <= wr_now;
    end
  end

  assign wr_commit = bus.CPUCE & wr_now & ~wr_q;
  assign snd_push  = wr_commit & is_port(bus.CPUAD, SND_A0, SND_A1);
  assign vid_wr    = wr_commit & is_port(bus.CPUAD, VID_A0, VID_A1);
  assign ovf_clr   = wr_commit & is_port(bus.CPUAD, STS_A0, STS_A1);

  always_ff @(posedge CLK48M or negedge RESETn) begin
    if (!RESETn)     VIDMD <= VIDMD_RST;
    else if (vid_wr) VIDMD <= bus.CPUDO;
  end

  // Frame-stable input snapshot; released (active-low) inputs read as FFh until the first VBLANK
  always_ff @(posedge CLK48M or negedge RESETn) begin
    if (!RESETn) begin
      vblk_q <= 1'b0;
      lat0   <= 8'hFF;
      lat1   <= 8'hFF;
      lat2   <= 8'hFF;
    end else begin
      vblk_q <= VBLK;
      if (VBLK & ~vblk_q) begin
        lat0 <= INP0;
        lat1 <= INP1;
        lat2 <= INP2;
      end
    end
  end

  assign inp0_v = INP_LATCH ? lat0 : INP0;
  assign inp1_v = INP_LATCH ? lat1 : INP1;
  assign inp2_v = INP_LATCH ? lat2 : INP2;

  segasys1_snd_fifo #(.DEPTH(SND_DEPTH)) u_snd_fifo (
    .CLK48M  (CLK48M),
    .RESETn  (RESETn),
    .push    (snd_push),
    .din     (bus.CPUDO),
    .pop     (SNDACK),
    .ovf_clr (ovf_clr),
    .head    (SNDNO),
    .empty   (snd_empty),
    .full    (snd_full),
    .count4  (snd_cnt),
    .ovf     (snd_ovf)
  );

  assign SNDRQ = ~snd_empty;

  always_comb begin
    status            = {4'b0000, snd_cnt};
    status[STS_OVF]   = snd_ovf;
    status[STS_EMPTY] = snd_empty;
    status[STS_FULL]  = snd_full;
  end

  // Input groups use A[4:2] only; the special ports occupy groups 101/110, so selects stay one-hot
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sel = '0;
    if (bus.CPUIORQ & bus.CPURD) begin
      sel.inp0 = (bus.CPUAD[4:2] == GRP_INP0);
      sel.inp1 = (bus.CPUAD[4:2] == GRP_INP1);
      sel.inp2 = (bus.CPUAD[4:2] == GRP_INP2);
      sel.dsw0 = (bus.CPUAD[4:2] == GRP_DSW) & ~bus.CPUAD[0];
      sel.dsw1 = ((bus.CPUAD[4:2] == GRP_DSW) & bus.CPUAD[0]) | (bus.CPUAD[4:2] == GRP_DSW1);
      sel.snd  = is_port(bus.CPUAD, SND_A0, SND_A1);
      sel.vid  = is_port(bus.CPUAD, VID_A0, VID_A1);
      sel.sts  = is_port(bus.CPUAD, STS_A0, STS_A1);
    end
  end

  always_comb begin
    rd_data = ({8{sel.inp0}} & inp0_v) | ({8{sel.inp1}} & inp1_v) |
              ({8{sel.inp2}} & inp2_v) | ({8{sel.dsw0}} & DSW0)   |
              ({8{sel.dsw1}} & DSW1)   | ({8{sel.snd}}  & SNDNO)  |
              ({8{sel.vid}}  & VIDMD)  | ({8{sel.sts}}  & status);
  end

  assign bus.DV = |sel;
  assign bus.OD = bus.DV ? rd_data : 8'hFF;

endmodule

// File: tb/tb_segasys1_io_ctrl.sv
// Directed bench for segasys1_io_ctrl: live-input instance (A) and VBLANK-latched
// instance (B) share the CPU bus; a queue model tracks the sound FIFO and read results.
module tb_segasys1_io_ctrl;
  import segasys1_io_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_a_n, rst_b_n;
  logic       ce, iorq, rd, wr;
  logic [7:0] ad, dout;
  logic [7:0] inp0, inp1, inp2, dsw0, dsw1;
  logic       vblk, ack;
  logic [7:0] vidmd_a, vidmd_b, sndno_a, sndno_b;
  logic       sndrq_a, sndrq_b;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] snd_q[$];
  logic       m_ovf = 1'b0;

  always #5 clk = ~clk;

  segasys1_io_ctrl_if bus_a ();
  segasys1_io_ctrl_if bus_b ();

  assign bus_a.CPUCE = ce;   assign bus_b.CPUCE = ce;
  assign bus_a.CPUAD = ad;   assign bus_b.CPUAD = ad;
  assign bus_a.CPUIORQ = iorq; assign bus_b.CPUIORQ = iorq;
  assign bus_a.CPURD = rd;   assign bus_b.CPURD = rd;
  assign bus_a.CPUWR = wr;   assign bus_b.CPUWR = wr;
  assign bus_a.CPUDO = dout; assign bus_b.CPUDO = dout;

  segasys1_io_ctrl #(.SND_DEPTH(DEPTH), .INP_LATCH(1'b0), .VIDMD_RST(8'h00)) u_dut_a (
    .CLK48M (clk), .RESETn (rst_a_n), .bus (bus_a),
    .INP0 (inp0), .INP1 (inp1), .INP2 (inp2), .DSW0 (dsw0), .DSW1 (dsw1),
    .VBLK (vblk), .VIDMD (vidmd_a), .SNDRQ (sndrq_a), .SNDNO (sndno_a), .SNDACK (ack)
  );

  segasys1_io_ctrl #(.SND_DEPTH(DEPTH), .INP_LATCH(1'b1), .VIDMD_RST(8'h3C)) u_dut_b (
    .CLK48M (clk), .RESETn (rst_b_n), .bus (bus_b),
    .INP0 (inp0), .INP1 (inp1), .INP2 (inp2), .DSW0 (dsw0), .DSW1 (dsw1),
    .VBLK (vblk), .VIDMD (vidmd_b), .SNDRQ (sndrq_b), .SNDNO (sndno_b), .SNDACK (ack)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] m_status();
    logic [3:0] c;
    c = 4'(snd_q.size());
    return {m_ovf, snd_q.size() == 0, snd_q.size() == DEPTH, 1'b0, c};
  endfunction

  function automatic logic [7:0] m_input(input logic [7:0] addr);
    case (addr[4:2])
      3'b000:  return inp0;
      3'b001:  return inp1;
      3'b010:  return inp2;
      3'b011:  return addr[0] ? dsw1 : dsw0;
      default: return dsw1;
    endcase
  endfunction

  task automatic cpu_cycle();
    @(negedge clk) ce = 1'b1;
    @(negedge clk) ce = 1'b0;
  endtask

  task automatic model_write(input logic [7:0] addr, input logic [7:0] data);
    if (addr == SND_A0 || addr == SND_A1) begin
      if (snd_q.size() < DEPTH) snd_q.push_back(data);
      else m_ovf = 1'b1;
    end
    if (addr == STS_A0 || addr == STS_A1) m_ovf = 1'b0;
  endtask

  task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
    iorq = 1'b1; wr = 1'b1; ad = addr; dout = data;
    cpu_cycle();
    model_write(addr, data);
    wr = 1'b0; iorq = 1'b0;
    cpu_cycle();
  endtask

  task automatic io_read(input string tag, input bit use_b, input logic [7:0] addr,
                         input logic [7:0] exp, input logic dv_exp);
    exp_q.push_back(exp);
    iorq = 1'b1; rd = 1'b1; ad = addr;
    #1;
    check(tag, use_b ? bus_b.OD : bus_a.OD, exp_q.pop_front());
    check({tag, "_dv"}, {7'b0, use_b ? bus_b.DV : bus_a.DV}, {7'b0, dv_exp});
    rd = 1'b0; iorq = 1'b0;
  endtask

  task automatic snd_ack();
    check("sndrq_before_ack", {7'b0, sndrq_a}, 8'h01);
    check("sndno_head", sndno_a, snd_q.pop_front());
    @(negedge clk) ack = 1'b1;
    @(negedge clk) ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    ce = 1'b0; iorq = 1'b0; rd = 1'b0; wr = 1'b0; ad = 8'h00; dout = 8'h00;
    inp0 = 8'h11; inp1 = 8'h22; inp2 = 8'h33; dsw0 = 8'h44; dsw1 = 8'h55;
    vblk = 1'b0; ack = 1'b0;
    repeat (3) @(negedge clk);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    @(negedge clk);

    // Reset state and read decode
    check("rst_vidmd_a", vidmd_a, 8'h00);
    check("rst_vidmd_b", vidmd_b, 8'h3C);
    check("rst_sndrq", {7'b0, sndrq_a}, 8'h00);
    check("rst_sndno", sndno_a, 8'h00);
    io_read("rst_latch_b", 1'b1, 8'h00, 8'hFF, 1'b1);
    for (int a = 0; a < 8'h14; a++) io_read("inp_decode", 1'b0, 8'(a), m_input(8'(a)), 1'b1);
    io_read("rst_status", 1'b0, STS_A0, 8'h40, 1'b1);
    io_read("rst_sndport", 1'b0, SND_A1, 8'h00, 1'b1);
    io_read("undecoded", 1'b0, 8'h1C, 8'hFF, 1'b0);
    cpu_cycle();

    // Held write strobe commits exactly once
    iorq = 1'b1; wr = 1'b1; ad = SND_A0; dout = 8'h5A;
    repeat (4) cpu_cycle();
    model_write(SND_A0, 8'h5A);
    wr = 1'b0; iorq = 1'b0;
    cpu_cycle();
    io_read("held_wr_status", 1'b0, STS_A1, m_status(), 1'b1);
    io_read("snd_readback", 1'b0, SND_A0, 8'h5A, 1'b1);
    snd_ack();
    check("sndrq_after_ack", {7'b0, sndrq_a}, 8'h00);

    // Overfill, drain, OVF sticky
    for (int i = 1; i <= 5; i++) io_write(SND_A1, 8'(i));
    io_read("full_ovf_status", 1'b0, STS_A0, m_status(), 1'b1);
    io_read("full_ovf_const", 1'b0, STS_A0, 8'hA4, 1'b1);
    repeat (4) snd_ack();
    io_read("drained_status", 1'b0, STS_A1, m_status(), 1'b1);
    ack = 1'b1; @(negedge clk) ack = 1'b0;
    io_read("pop_empty_status", 1'b0, STS_A1, 8'hC0, 1'b1);
    io_write(STS_A1, 8'h00);
    io_read("ovf_cleared", 1'b0, STS_A0, m_status(), 1'b1);

    // Full FIFO: push and pop on the same clock
    io_write(SND_A0, 8'h11); io_write(SND_A0, 8'h22);
    io_write(SND_A0, 8'h33); io_write(SND_A0, 8'h44);
    io_read("full_no_ovf", 1'b0, STS_A0, m_status(), 1'b1);
    check("pushpop_head", sndno_a, snd_q.pop_front());
    iorq = 1'b1; wr = 1'b1; ad = SND_A0; dout = 8'h77;
    @(negedge clk) begin ce = 1'b1; ack = 1'b1; end
    @(negedge clk) begin ce = 1'b0; ack = 1'b0; end
    model_write(SND_A0, 8'h77);
    wr = 1'b0; iorq = 1'b0;
    cpu_cycle();
    io_read("pushpop_status", 1'b0, STS_A0, 8'h24, 1'b1);
    repeat (4) snd_ack();
    io_read("pushpop_drained", 1'b0, STS_A0, m_status(), 1'b1);

    // Video mode latch and OVF clear via port 16h
    io_write(VID_A1, 8'hA5);
    check("vidmd_a", vidmd_a, 8'hA5);
    io_read("vid_rd15", 1'b0, VID_A0, 8'hA5, 1'b1);
    io_read("vid_rd19", 1'b0, VID_A1, 8'hA5, 1'b1);
    for (int i = 0; i < 5; i++) io_write(SND_A0, 8'(8'hE0 + i));
    io_read("ovf_rd1", 1'b0, STS_A0, m_status(), 1'b1);
    io_read("ovf_rd2_no_side_effect", 1'b0, STS_A1, 8'hA4, 1'b1);
    io_write(STS_A0, 8'hFF);
    io_read("ovf_clear_16", 1'b0, STS_A0, m_status(), 1'b1);

    // VBLANK-latched inputs on instance B
    vblk = 1'b1; repeat (2) @(negedge clk); vblk = 1'b0; @(negedge clk);
    io_read("latch_first_frame", 1'b1, 8'h00, 8'h11, 1'b1);
    inp0 = 8'h99;
    io_read("live_changed", 1'b0, 8'h00, 8'h99, 1'b1);
    io_read("latch_holds_old", 1'b1, 8'h00, 8'h11, 1'b1);
    vblk = 1'b1; repeat (2) @(negedge clk); vblk = 1'b0; @(negedge clk);
    io_read("latch_new_frame", 1'b1, 8'h00, 8'h99, 1'b1);

    // Write strobe held across a reset of instance B does not commit
    iorq = 1'b1; wr = 1'b1; ad = VID_A0; dout = 8'h77;
    @(negedge clk) rst_b_n = 1'b0;
    cpu_cycle();
    @(negedge clk) rst_b_n = 1'b1;
    repeat (2) cpu_cycle();
    wr = 1'b0; iorq = 1'b0;
    cpu_cycle();
    check("rst_midwrite_vidmd_b", vidmd_b, 8'h3C);
    io_read("rst_midwrite_latch_b", 1'b1, 8'h00, 8'hFF, 1'b1);
    io_write(VID_A0, 8'h5C);
    check("post_rst_write_b", vidmd_b, 8'h5C);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
